// File: rtl/magnetron_sequencer.sv
// Microwave cook-cycle sequencer.
// Turns the front-panel presses and the door switch into IDLE/COOK/PAUSE/DONE.
// Counts the cook time down in seconds.
// Duty-cycles the magnetron over a 10-slot (10 s) window by latched power level.
module magnetron_sequencer #(
   parameter int TICKS_PER_SEC = 50000000,
   parameter int TWIDTH        = 13,
   parameter int BEEP_SECS     = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              comecaN,
   input  logic              pareN,
   input  logic              limpaN,
   input  logic              portafechada,
   input  logic [TWIDTH-1:0] tempo_in,
   input  logic [3:0]        potencia,
   output logic              magnetron,
   output logic [TWIDTH-1:0] tempo,
   output logic [1:0]        estado,
   output logic              beep,
   output logic              done
);

   localparam int PW = $clog2(TICKS_PER_SEC);
   localparam int BW = $clog2(BEEP_SECS + 1);
   localparam logic [PW-1:0]     PRESC_MAX  = PW'(TICKS_PER_SEC - 1);
   localparam logic [PW-1:0]     PRESC_ONE  = PW'(1);
   localparam logic [BW-1:0]     BEEP_LAST  = BW'(BEEP_SECS - 1);
   localparam logic [BW-1:0]     BEEP_ONE   = BW'(1);
   localparam logic [TWIDTH-1:0] TEMPO_ONE  = TWIDTH'(1);
   localparam logic [TWIDTH-1:0] TEMPO_ZERO = TWIDTH'(0);

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_COOK  = 2'b01,
      S_PAUSE = 2'b10,
      S_DONE  = 2'b11
   } state_t;

   // Power level 0 still cooks a little (one slot); anything above 10 is continuous.
   function automatic logic [3:0] clamp_power(input logic [3:0] p);
      if (p == 4'd0) begin
         return 4'd1;
      end else if (p > 4'd10) begin
         return 4'd10;
      end else begin
         return p;
      end
   endfunction

   state_t            state_q, state_d;
   logic [TWIDTH-1:0] tempo_q, tempo_d;
   logic [PW-1:0]     presc_q, presc_d;
   logic [3:0]        slot_q, slot_d;
   logic [3:0]        pwr_q, pwr_d;
   logic [BW-1:0]     bsec_q, bsec_d;
   logic              comeca_prev_q, pare_prev_q, limpa_prev_q;
   logic              magnetron_q, magnetron_d;
   logic              beep_q, beep_d;
   logic              done_q, done_d;

   logic comeca_s, pare_s, limpa_s, any_press_s, tick_s;

   // A press is a 1->0 transition against the previous sample, so holding never re-triggers.
   assign comeca_s    = comeca_prev_q & ~comecaN;
   assign pare_s      = pare_prev_q & ~pareN;
   assign limpa_s     = limpa_prev_q & ~limpaN;
   assign any_press_s = comeca_s | pare_s | limpa_s;
   assign tick_s      = (presc_q == PRESC_MAX);

   // Next-state logic: limpa > pare > door open > second tick > comeca within each state.
   always_comb begin
      state_d = state_q;
      tempo_d = tempo_q;
      presc_d = presc_q;
      slot_d  = slot_q;
      pwr_d   = pwr_q;
      bsec_d  = bsec_q;
      case (state_q)
         S_IDLE: begin
            if (limpa_s) begin
               tempo_d = TEMPO_ZERO;
            end else if (comeca_s && portafechada && (tempo_in != TEMPO_ZERO)) begin
               tempo_d = tempo_in;
               pwr_d   = clamp_power(potencia);
               presc_d = '0;
               slot_d  = 4'd0;
               state_d = S_COOK;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_COOK: begin
            if (limpa_s) begin
               tempo_d = TEMPO_ZERO;
               state_d = S_IDLE;
            end else if (pare_s || !portafechada) begin
               // Everything holds; the tick on this edge (if any) is dropped.
               state_d = S_PAUSE;
            end else if (tick_s) begin
               presc_d = '0;
               tempo_d = tempo_q - TEMPO_ONE;
               slot_d  = (slot_q == 4'd9) ? 4'd0 : (slot_q + 4'd1);
               if (tempo_q == TEMPO_ONE) begin
                  // Prescaler restarts at 0 and now times the beep.
                  bsec_d  = '0;
                  state_d = S_DONE;
               end else begin
                  state_d = S_COOK;
               end
            end else begin
               presc_d = presc_q + PRESC_ONE;
            end
         end
         S_PAUSE: begin
            if (limpa_s || pare_s) begin
               tempo_d = TEMPO_ZERO;
               state_d = S_IDLE;
            end else if (comeca_s && portafechada) begin
               state_d = S_COOK;
            end else begin
               state_d = S_PAUSE;
            end
         end
         S_DONE: begin
            if (any_press_s) begin
               state_d = S_IDLE;
            end else if (tick_s) begin
               presc_d = '0;
               if (bsec_q == BEEP_LAST) begin
                  state_d = S_IDLE;
               end else begin
                  bsec_d = bsec_q + BEEP_ONE;
               end
            end else begin
               presc_d = presc_q + PRESC_ONE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      magnetron_d = (state_d == S_COOK) && (slot_d < pwr_d) && portafechada;
      beep_d      = (state_d == S_DONE);
      done_d      = (state_d == S_DONE) && (state_q != S_DONE);
   end

   // State, counters, button history and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         tempo_q       <= TEMPO_ZERO;
         presc_q       <= '0;
         slot_q        <= 4'd0;
         pwr_q         <= 4'd0;
         bsec_q        <= '0;
         comeca_prev_q <= 1'b1;
         pare_prev_q   <= 1'b1;
         limpa_prev_q  <= 1'b1;
         magnetron_q   <= 1'b0;
         beep_q        <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         tempo_q       <= tempo_d;
         presc_q       <= presc_d;
         slot_q        <= slot_d;
         pwr_q         <= pwr_d;
         bsec_q        <= bsec_d;
         comeca_prev_q <= comecaN;
         pare_prev_q   <= pareN;
         limpa_prev_q  <= limpaN;
         magnetron_q   <= magnetron_d;
         beep_q        <= beep_d;
         done_q        <= done_d;
      end
   end

   assign magnetron = magnetron_q;
   assign tempo     = tempo_q;
   assign estado    = state_q;
   assign beep      = beep_q;
   assign done      = done_q;

endmodule

// File: tb/tb_magnetron_sequencer.sv
// Directed bench for magnetron_sequencer with TICKS_PER_SEC=4, BEEP_SECS=3.
module tb_magnetron_sequencer;

   localparam int TW = 13;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          comecaN = 1'b1;
   logic          pareN = 1'b1;
   logic          limpaN = 1'b1;
   logic          portafechada = 1'b1;
   logic [TW-1:0] tempo_in = 13'd0;
   logic [3:0]    potencia = 4'd0;
   logic          magnetron;
   logic [TW-1:0] tempo;
   logic [1:0]    estado;
   logic          beep;
   logic          done;

   int n_checks = 0;
   int n_pass   = 0;
   int n_cook, n_mag, n_beep, n_done;

   magnetron_sequencer #(
      .TICKS_PER_SEC(4),
      .TWIDTH(TW),
      .BEEP_SECS(3)
   ) dut (
      .clk(clk),
      .rst(rst),
      .comecaN(comecaN),
      .pareN(pareN),
      .limpaN(limpaN),
      .portafechada(portafechada),
      .tempo_in(tempo_in),
      .potencia(potencia),
      .magnetron(magnetron),
      .tempo(tempo),
      .estado(estado),
      .beep(beep),
      .done(done)
   );

   // Free-running clock; inputs change and outputs are sampled on the falling edge.
   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got == exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic clear_counts();
      n_cook = 0; n_mag = 0; n_beep = 0; n_done = 0;
   endtask

   // Account the current cycle (outputs plus the inputs driving the next edge), then advance.
   task automatic step();
      if (estado == 2'b01 && portafechada) n_cook++;
      if (magnetron) n_mag++;
      if (beep) n_beep++;
      if (done) n_done++;
      @(negedge clk);
   endtask

   task automatic press_start(input int t, input int p);
      tempo_in = t[TW-1:0];
      potencia = p[3:0];
      comecaN  = 1'b0;
      step();
      comecaN  = 1'b1;
   endtask

   initial begin
      // 1. Reset
      rst = 1'b1;
      step();
      step();
      check("rst_estado", estado, 0);
      check("rst_tempo", tempo, 0);
      check("rst_mag", magnetron, 0);
      check("rst_beep", beep, 0);
      check("rst_done", done, 0);
      rst = 1'b0;
      step();

      // 2. Full cook, power 10, 3 s
      clear_counts();
      press_start(3, 10);
      check("full_start_estado", estado, 1);
      check("full_start_mag", magnetron, 1);
      check("full_start_tempo", tempo, 3);
      for (int k = 1; k <= 30; k++) begin
         step();
         if (k == 3)  check("full_t3", tempo, 3);
         if (k == 4)  check("full_t4", tempo, 2);
         if (k == 8)  check("full_t8", tempo, 1);
         if (k == 12) begin
            check("full_done_estado", estado, 3);
            check("full_done_pulse", done, 1);
            check("full_done_beep", beep, 1);
            check("full_done_tempo", tempo, 0);
         end
         if (k == 13) check("full_done_once", done, 0);
      end
      check("full_mag_cycles", n_mag, 12);
      check("full_beep_cycles", n_beep, 12);
      check("full_done_count", n_done, 1);
      check("full_end_estado", estado, 0);

      // 3. Duty cycle, power 3, 10 s
      clear_counts();
      press_start(10, 3);
      for (int k = 1; k <= 60; k++) begin
         step();
         if (k == 11) check("duty_k11_on", magnetron, 1);
         if (k == 12) check("duty_k12_off", magnetron, 0);
         if (k == 39) check("duty_k39_off", magnetron, 0);
         if (k == 40) check("duty_k40_done", estado, 3);
      end
      check("duty_mag_cycles", n_mag, 12);
      check("duty_cook_cycles", n_cook, 40);
      check("duty_tempo_end", tempo, 0);

      // 4. Door interlock, 5 s cook
      clear_counts();
      press_start(5, 10);
      repeat (5) step();
      portafechada = 1'b0;
      step();
      check("door_pause", estado, 2);
      check("door_mag", magnetron, 0);
      check("door_tempo", tempo, 4);
      portafechada = 1'b1;
      repeat (3) step();
      check("door_close_stays", estado, 2);
      check("door_close_tempo", tempo, 4);
      comecaN = 1'b0;
      step();
      comecaN = 1'b1;
      check("door_resume", estado, 1);
      check("door_resume_mag", magnetron, 1);
      for (int i = 0; i < 100 && estado != 2'b11; i++) step();
      check("door_reach_done", estado, 3);
      check("door_cook_cycles", n_cook, 20);
      repeat (15) step();
      check("door_end_idle", estado, 0);

      // 5. Button priority and edge detection
      tempo_in = 13'd5;
      potencia = 4'd10;
      limpaN   = 1'b0;
      comecaN  = 1'b0;
      step();
      check("prio_limpa_estado", estado, 0);
      check("prio_limpa_tempo", tempo, 0);
      limpaN = 1'b1;
      repeat (9) step();
      check("hold_no_start", estado, 0);
      comecaN = 1'b1;
      step();
      comecaN = 1'b0;
      step();
      comecaN = 1'b1;
      check("repress_start", estado, 1);
      check("repress_tempo", tempo, 5);
      pareN = 1'b0;
      step();
      check("pare1_pause", estado, 2);
      pareN = 1'b1;
      step();
      pareN = 1'b0;
      step();
      pareN = 1'b1;
      check("pare2_idle", estado, 0);
      check("pare2_tempo", tempo, 0);
      step();

      // 6. Reset mid-cook, invalid start, power clamp
      press_start(5, 10);
      repeat (2) step();
      check("midrst_pre_mag", magnetron, 1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("midrst_estado", estado, 0);
      check("midrst_mag", magnetron, 0);
      check("midrst_tempo", tempo, 0);
      step();
      press_start(0, 10);
      check("zero_time_idle", estado, 0);
      step();
      clear_counts();
      press_start(10, 0);
      check("clamp_start_tempo", tempo, 10);
      for (int k = 1; k <= 40; k++) step();
      check("clamp_mag_cycles", n_mag, 4);
      check("clamp_cook_cycles", n_cook, 40);
      check("clamp_done", estado, 3);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   // Hard time limit so the run always ends.
   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
